// File: rtl/keycode_repeat_filter.sv
// keycode_repeat_filter
//   Locks onto one WASD movement key from the four HID keycode slots and
//   emits it once per frame with typematic gating (first press, initial
//   delay, repeat rate), all counted in frames.
//   Build option: define KEY_REPEAT_EN to enable the DELAY/REPEAT gating.
//   Without it the locked key is emitted on every frame tick.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | no movement key locked
//   DELAY  | key emitted once, waiting out the initial typematic delay
//   REPEAT | key emitted every RATE_FRAMES frames while still held
module keycode_repeat_filter #(
   parameter int DELAY_FRAMES = 15,
   parameter int RATE_FRAMES  = 3
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode0,
   input  logic [7:0] keycode1,
   input  logic [7:0] keycode2,
   input  logic [7:0] keycode3,
   output logic [7:0] keycode_out,
   output logic       key_held
);

   if (DELAY_FRAMES < 1 || DELAY_FRAMES > 255 || RATE_FRAMES < 1 || RATE_FRAMES > 255) begin : g_param_check
      $error("keycode_repeat_filter: DELAY_FRAMES and RATE_FRAMES must be 1..255");
   end

   function automatic logic is_move(input logic [7:0] k);
      return (k == 8'h04) || (k == 8'h07) || (k == 8'h16) || (k == 8'h1A);
   endfunction

   logic       sync1_q, sync2_q, prev_q;
   logic [1:0] fill_q;
   logic       frame_tick;
   logic [7:0] slot0_q, slot1_q, slot2_q, slot3_q;
   logic [7:0] lock_q, lock_d;
   logic [7:0] out_q, out_d;
   logic       held_q, held_d;
   logic       lock_hit;
   logic       new_valid;
   logic [7:0] new_key;

   // Synchronise vsync and detect its rising edge. prev is forced high until
   // real samples have filled the sync chain, so a frame_clk already high at
   // reset release cannot fake a tick.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b1;
         fill_q  <= 2'b00;
      end else begin
         sync1_q <= frame_clk;
         sync2_q <= sync1_q;
         prev_q  <= fill_q[1] ? sync2_q : 1'b1;
         fill_q  <= {fill_q[0], 1'b1};
      end
   end

   assign frame_tick = sync2_q & ~prev_q;

   // Register the keycode slots every cycle.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         slot0_q <= 8'h00;
         slot1_q <= 8'h00;
         slot2_q <= 8'h00;
         slot3_q <= 8'h00;
      end else begin
         slot0_q <= keycode0;
         slot1_q <= keycode1;
         slot2_q <= keycode2;
         slot3_q <= keycode3;
      end
   end

   // Key selection: is the locked key still present, else lowest-index movement key.
   always_comb begin
      lock_hit  = (lock_q != 8'h00) &&
                  ((slot0_q == lock_q) || (slot1_q == lock_q) ||
                   (slot2_q == lock_q) || (slot3_q == lock_q));
      new_valid = 1'b1;
      new_key   = 8'h00;
      if (is_move(slot0_q))      new_key = slot0_q;
      else if (is_move(slot1_q)) new_key = slot1_q;
      else if (is_move(slot2_q)) new_key = slot2_q;
      else if (is_move(slot3_q)) new_key = slot3_q;
      else                       new_valid = 1'b0;
   end

`ifdef KEY_REPEAT_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   localparam logic [7:0] DELAY_RELOAD = 8'(DELAY_FRAMES - 1);
   localparam logic [7:0] RATE_RELOAD  = 8'(RATE_FRAMES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   // Typematic state and frame counter; reloaded at zero so it never wraps.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Per-tick next state and gated output.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lock_d  = lock_q;
      out_d   = out_q;
      if (frame_tick) begin
         if (lock_hit) begin
            out_d = 8'h00;
            if (state_q != IDLE) begin
               if (cnt_q == 8'h00) begin
                  out_d   = lock_q;
                  cnt_d   = RATE_RELOAD;
                  state_d = REPEAT;
               end else begin
                  cnt_d = cnt_q - 8'h01;
               end
            end
         end else if (new_valid) begin
            lock_d  = new_key;
            out_d   = new_key;
            cnt_d   = DELAY_RELOAD;
            state_d = DELAY;
         end else begin
            lock_d  = 8'h00;
            out_d   = 8'h00;
            cnt_d   = 8'h00;
            state_d = IDLE;
         end
      end
      held_d = (lock_d != 8'h00);
   end
`else
   // Per-tick output: emit the locked key on every frame it is held.
   always_comb begin
      lock_d = lock_q;
      out_d  = out_q;
      if (frame_tick) begin
         if (lock_hit) begin
            out_d = lock_q;
         end else if (new_valid) begin
            lock_d = new_key;
            out_d  = new_key;
         end else begin
            lock_d = 8'h00;
            out_d  = 8'h00;
         end
      end
      held_d = (lock_d != 8'h00);
   end
`endif

   // Output and lock registers, held stable between frame ticks.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         lock_q <= 8'h00;
         out_q  <= 8'h00;
         held_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
         out_q  <= out_d;
         held_q <= held_d;
      end
   end

   assign keycode_out = out_q;
   assign key_held    = held_q;

endmodule

// File: tb/tb_keycode_repeat_filter.sv
// Directed testbench for keycode_repeat_filter; expectations follow the
// KEY_REPEAT_EN setting the design is built with.
module tb_keycode_repeat_filter;

   localparam int D = 15;
   localparam int R = 3;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk = 1'b0;
   logic [7:0] keycode0 = 8'h00;
   logic [7:0] keycode1 = 8'h00;
   logic [7:0] keycode2 = 8'h00;
   logic [7:0] keycode3 = 8'h00;
   logic [7:0] keycode_out;
   logic       key_held;

   int n_checks = 0;
   int n_pass   = 0;

   keycode_repeat_filter #(.DELAY_FRAMES(D), .RATE_FRAMES(R)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .keycode0   (keycode0),
      .keycode1   (keycode1),
      .keycode2   (keycode2),
      .keycode3   (keycode3),
      .keycode_out(keycode_out),
      .key_held   (key_held)
   );

   always #10 Clk = ~Clk;

   // Frame n counted from the tick that locked the key.
   function automatic bit emits(input int n);
`ifdef KEY_REPEAT_EN
      return (n == 0) || ((n >= D) && (((n - D) % R) == 0));
`else
      return 1'b1;
`endif
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic frame();
      @(negedge Clk) frame_clk = 1'b1;
      repeat (8) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (8) @(negedge Clk);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] key, input int n);
      check(tag, keycode_out, emits(n) ? key : 8'h00);
      check({tag, "_held"}, {7'd0, key_held}, 8'h01);
   endtask

   initial begin
      // reset with empty slots
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("rst_out", keycode_out, 8'h00);
      check("rst_held", {7'd0, key_held}, 8'h00);
      for (int i = 0; i < 5; i++) begin
         frame();
         check("idle_out", keycode_out, 8'h00);
         check("idle_held", {7'd0, key_held}, 8'h00);
      end

      // D held for 20 frames
      keycode0 = 8'h07;
      for (int n = 0; n < 20; n++) begin
         frame();
         check_frame($sformatf("hold07_f%0d", n), 8'h07, n);
      end
      keycode0 = 8'h00;
      frame();
      check("rel07_out", keycode_out, 8'h00);
      check("rel07_held", {7'd0, key_held}, 8'h00);

      // A locked, W added, then A dropped
      keycode0 = 8'h04;
      for (int n = 0; n < 3; n++) begin
         frame();
         check_frame($sformatf("lock04_f%0d", n), 8'h04, n);
      end
      keycode1 = 8'h1A;
      for (int n = 3; n < 17; n++) begin
         frame();
         check_frame($sformatf("keep04_f%0d", n), 8'h04, n);
      end
      keycode0 = 8'h00;
      for (int n = 0; n < 3; n++) begin
         frame();
         check_frame($sformatf("new1A_f%0d", n), 8'h1A, n);
      end
      keycode1 = 8'h00;
      frame();
      check("rel1A_out", keycode_out, 8'h00);

      // non-movement code in lower slot is ignored
      keycode0 = 8'h2C;
      keycode1 = 8'h16;
      frame();
      check_frame("sel16_f0", 8'h16, 0);
      keycode0 = 8'h00;
      keycode1 = 8'h00;
      frame();
      check("rel16_out", keycode_out, 8'h00);

      // reset mid-DELAY with frame_clk high
      keycode0 = 8'h07;
      frame();
      check_frame("pre_rst_f0", 8'h07, 0);
      frame();
      check_frame("pre_rst_f1", 8'h07, 1);
      frame_clk = 1'b1;
      repeat (8) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check("midrst_out", keycode_out, 8'h00);
      check("midrst_held", {7'd0, key_held}, 8'h00);
      repeat (12) @(negedge Clk);
      check("no_tick_out", keycode_out, 8'h00);
      check("no_tick_held", {7'd0, key_held}, 8'h00);
      frame_clk = 1'b0;
      repeat (8) @(negedge Clk);
      frame();
      check_frame("post_rst_f0", 8'h07, 0);
      frame();
      check_frame("post_rst_f1", 8'h07, 1);
      keycode0 = 8'h00;
      frame();
      check("post_rst_rel", keycode_out, 8'h00);

      // D in slot 2 for 5 frames, then release
      keycode2 = 8'h07;
      for (int n = 0; n < 5; n++) begin
         frame();
         check_frame($sformatf("slot2_f%0d", n), 8'h07, n);
      end
      keycode2 = 8'h00;
      frame();
      check("slot2_rel_out", keycode_out, 8'h00);
      check("slot2_rel_held", {7'd0, key_held}, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
